// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared encodings for the multicycle register-file sequencer: MIPS opcode and
// funct values the sequencer understands, ALU operation codes, the FSM state
// encoding and a helper that selects the register-file write target.
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type funct values (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  // R-type instructions write rd, everything else writes rt.
  function automatic logic [4:0] write_target(input logic [4:0] rd_f,
                                              input logic [4:0] rt_f,
                                              input logic       reg_dst);
    return reg_dst ? rd_f : rt_f;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// -----------------------------------------------------------------------------
// mc_decode
// Purely combinational instruction classifier for the sequencer.
// Ports:
//   opcode     in  6  instr[31:26]
//   funct      in  6  instr[5:0], only meaningful for R-type
//   legal      out 1  opcode/funct combination is supported
//   reg_dst    out 1  write rd (R-type) rather than rt
//   alu_src    out 1  operand2 comes from the immediate
//   alu_op     out 3  ALU operation code
//   is_lw      out 1  load word
//   is_sw      out 1  store word
//   is_beq     out 1  branch if equal
//   writes_reg out 1  instruction produces a register-file write
// -----------------------------------------------------------------------------
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       legal,
  output logic       reg_dst,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       writes_reg
);

  always_comb begin
    legal      = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    writes_reg = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal      = 1'b1;
        reg_dst    = 1'b1;
        writes_reg = 1'b1;
        case (funct)
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_SUB: alu_op = ALU_SUB;
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_SLT: alu_op = ALU_SLT;
          default: begin
            legal      = 1'b0;
            reg_dst    = 1'b0;
            writes_reg = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        legal      = 1'b1;
        alu_src    = 1'b1;
        writes_reg = 1'b1;
      end
      OP_LW: begin
        legal      = 1'b1;
        alu_src    = 1'b1;
        is_lw      = 1'b1;
        writes_reg = 1'b1;
      end
      OP_SW: begin
        legal   = 1'b1;
        alu_src = 1'b1;
        is_sw   = 1'b1;
      end
      OP_BEQ: begin
        legal  = 1'b1;
        is_beq = 1'b1;
        alu_op = ALU_SUB;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_regfile_sequencer.sv
// -----------------------------------------------------------------------------
// mc_regfile_sequencer
// Multicycle control FSM between instruction fetch and the register-file /
// ALU / data-memory datapath. Accepts one instruction per valid/ready
// handshake and steps it through DECODE, EXECUTE, optional MEM and optional
// WRITEBACK. All outputs are decoded from the state and the latched IR,
// except the MEM-state strobes/done/mem_err which also look at mem_ready.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   instr, instr_valid    instruction word and its valid (from fetch)
//   instr_ready           sequencer is idle and will take an instruction
//   mem_ready             data memory finished the current access
//   rs, rt, rd            register address fields of the IR
//   RegDst, ALUSrc        write-port select, immediate operand select
//   RegWrite              one-cycle register-file write strobe
//   alu_op                ALU operation code
//   mem_read, mem_write   data-memory strobes, held during MEM
//   branch                beq compare cycle
//   done, illegal, mem_err  one-cycle retire / bad-instruction / timeout pulses
// Parameters:
//   MEM_TIMEOUT           MEM wait count at which the access is abandoned
//   TO_W                  width of the MEM wait counter
// -----------------------------------------------------------------------------
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | instr_ready high, waiting for a handshake
// S_DECODE    | IR classified; unsupported instructions pulse illegal
// S_EXECUTE   | ALU controls valid; beq compares and retires here
// S_MEM       | lw/sw strobe held until mem_ready or timeout
// S_WRITEBACK | register write (unless the target is r0) and retire
// -----------------------------------------------------------------------------
module mc_regfile_sequencer
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        mem_ready,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [2:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        done,
  output logic        illegal,
  output logic        mem_err
);

  state_t            state_q, state_d;
  logic [31:0]       ir_q;
  logic [TO_W-1:0]   cnt_q;
  logic              accept;
  logic              mem_timeout;

  logic              dec_legal;
  logic              dec_reg_dst;
  logic              dec_alu_src;
  logic [2:0]        dec_alu_op;
  logic              dec_is_lw;
  logic              dec_is_sw;
  logic              dec_is_beq;
  logic              dec_writes_reg;
  logic [4:0]        wr_target;

  // Shift amount is not used by any supported instruction.
  logic              unused_shamt;
  assign unused_shamt = ^ir_q[10:6];

  mc_decode u_decode (
    .opcode     (ir_q[31:26]),
    .funct      (ir_q[5:0]),
    .legal      (dec_legal),
    .reg_dst    (dec_reg_dst),
    .alu_src    (dec_alu_src),
    .alu_op     (dec_alu_op),
    .is_lw      (dec_is_lw),
    .is_sw      (dec_is_sw),
    .is_beq     (dec_is_beq),
    .writes_reg (dec_writes_reg)
  );

  // Gated by rst so fetch never sees ready while the reset is still applied.
  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign accept      = instr_ready && instr_valid;
  assign mem_timeout = (cnt_q == TO_W'(MEM_TIMEOUT));
  assign wr_target   = write_target(ir_q[15:11], ir_q[20:16], dec_reg_dst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ir_q <= instr;
      end
      // Counts MEM cycles spent without mem_ready; cleared everywhere else
      // so each access starts from zero.
      if (state_q == S_MEM && !mem_ready) begin
        cnt_q <= cnt_q + TO_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rs        = '0;
    rt        = '0;
    rd        = '0;
    RegDst    = 1'b0;
    ALUSrc    = 1'b0;
    RegWrite  = 1'b0;
    alu_op    = ALU_ADD;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    mem_err   = 1'b0;

    if (state_q != S_IDLE) begin
      rs = ir_q[25:21];
      rt = ir_q[20:16];
      rd = ir_q[15:11];
    end

    // ALU/path controls are held from EXECUTE to the end of the instruction
    // so the datapath sees stable selects across MEM and WRITEBACK.
    if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WRITEBACK) begin
      RegDst = dec_reg_dst;
      ALUSrc = dec_alu_src;
      alu_op = dec_alu_op;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_DECODE;
      end
      S_DECODE: begin
        illegal = !dec_legal;
        state_d = dec_legal ? S_EXECUTE : S_IDLE;
      end
      S_EXECUTE: begin
        branch = dec_is_beq;
        done   = dec_is_beq;
        if (dec_is_beq)                  state_d = S_IDLE;
        else if (dec_is_lw || dec_is_sw) state_d = S_MEM;
        else                             state_d = S_WRITEBACK;
      end
      S_MEM: begin
        // mem_ready takes priority over the timeout on the same cycle.
        if (mem_ready) begin
          mem_read  = dec_is_lw;
          mem_write = dec_is_sw;
          done      = dec_is_sw;
          state_d   = dec_is_lw ? S_WRITEBACK : S_IDLE;
        end else if (mem_timeout) begin
          mem_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          mem_read  = dec_is_lw;
          mem_write = dec_is_sw;
        end
      end
      S_WRITEBACK: begin
        RegWrite = dec_writes_reg && (wr_target != 5'd0);
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_regfile_sequencer.sv
module tb_mc_regfile_sequencer;

  localparam int MEM_TIMEOUT = 15;
  localparam int TO_W        = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        mem_ready;
  logic [4:0]  rs, rt, rd;
  logic        RegDst, ALUSrc, RegWrite;
  logic [2:0]  alu_op;
  logic        mem_read, mem_write, branch, done, illegal, mem_err;
  logic [27:0] all_outs;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int functs [5] = '{32, 34, 36, 37, 42};

  always #5 clk = ~clk;

  mc_regfile_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .mem_ready   (mem_ready),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .RegDst      (RegDst),
    .ALUSrc      (ALUSrc),
    .RegWrite    (RegWrite),
    .alu_op      (alu_op),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .branch      (branch),
    .done        (done),
    .illegal     (illegal),
    .mem_err     (mem_err)
  );

  assign all_outs = {instr_ready, rs, rt, rd, RegDst, ALUSrc, RegWrite, alu_op,
                     mem_read, mem_write, branch, done, illegal, mem_err};

  typedef struct packed {
    logic       legal;
    logic       lw;
    logic       sw;
    logic       beq;
    logic       rdst;
    logic       asrc;
    logic       wr;
    logic [2:0] alu;
    logic [4:0] tgt;
  } exp_t;

  // Reference classification straight from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic writes;
    e = '0;
    writes = 1'b0;
    case (int'(w[31:26]))
      0: for (int i = 0; i < 5; i++)
           if (int'(w[5:0]) == functs[i]) begin
             e.legal = 1'b1; e.alu = 3'(i); e.rdst = 1'b1; writes = 1'b1;
           end
      8:  begin e.legal = 1'b1; e.asrc = 1'b1; writes = 1'b1; end
      35: begin e.legal = 1'b1; e.asrc = 1'b1; e.lw = 1'b1; writes = 1'b1; end
      43: begin e.legal = 1'b1; e.asrc = 1'b1; e.sw = 1'b1; end
      4:  begin e.legal = 1'b1; e.beq = 1'b1; e.alu = 3'd1; end
      default: ;
    endcase
    e.tgt = e.rdst ? w[15:11] : w[20:16];
    e.wr  = writes && (e.tgt != 5'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    #1;
    chk({tag, ".idle_ready"}, instr_ready, 1);
    chk({tag, ".idle_done"},  done, 0);
    chk({tag, ".idle_wr"},    RegWrite, 0);
    chk({tag, ".idle_rs"},    rs, 0);
  endtask

  // Issue one instruction and follow it cycle by cycle until it is back in
  // IDLE. mem_wait: MEM cycle (1-based) on which mem_ready is raised, or a
  // value outside 1..MEM_TIMEOUT+1 for "never".
  task automatic run_instr(input logic [31:0] w, input int mem_wait, input string tag);
    exp_t e;
    int   strobes;
    bit   timed_out;
    e = model(w);
    timed_out = !(mem_wait >= 1 && mem_wait <= MEM_TIMEOUT + 1);
    chk({tag, ".ready"}, instr_ready, 1);
    instr = w;
    instr_valid = 1'b1;
    tick;
    // Decode cycle: fetch keeps offering a different word, which must be ignored.
    instr = $urandom;
    #1;
    chk({tag, ".dec_ready"},   instr_ready, 0);
    chk({tag, ".dec_rs"},      rs, w[25:21]);
    chk({tag, ".dec_rt"},      rt, w[20:16]);
    chk({tag, ".dec_rd"},      rd, w[15:11]);
    chk({tag, ".dec_illegal"}, illegal, !e.legal);
    chk({tag, ".dec_done"},    done, 0);
    if (!e.legal) begin
      tick;
      idle_checks(tag);
      return;
    end
    tick;
    chk({tag, ".ex_alu"},    alu_op, e.alu);
    chk({tag, ".ex_regdst"}, RegDst, e.rdst);
    chk({tag, ".ex_alusrc"}, ALUSrc, e.asrc);
    chk({tag, ".ex_branch"}, branch, e.beq);
    chk({tag, ".ex_done"},   done, e.beq);
    chk({tag, ".ex_wr"},     RegWrite, 0);
    chk({tag, ".ex_mem"},    {mem_read, mem_write}, 0);
    if (e.beq) begin
      tick;
      idle_checks(tag);
      return;
    end
    if (e.lw || e.sw) begin
      strobes = 0;
      for (int m = 1; m <= MEM_TIMEOUT + 1; m++) begin
        tick;
        mem_ready = (m == mem_wait);
        #1;
        if (mem_read || mem_write) strobes++;
        chk({tag, ".mem_wr"}, RegWrite, 0);
        chk({tag, ".mem_rs"}, rs, w[25:21]);
        if (mem_ready) begin
          chk({tag, ".mem_ok_strobe"}, {mem_read, mem_write}, {e.lw, e.sw});
          chk({tag, ".mem_ok_done"},   done, e.sw);
          chk({tag, ".mem_ok_err"},    mem_err, 0);
          break;
        end else if (m == MEM_TIMEOUT + 1) begin
          chk({tag, ".mem_to_err"},    mem_err, 1);
          chk({tag, ".mem_to_strobe"}, {mem_read, mem_write}, 0);
          chk({tag, ".mem_to_done"},   done, 0);
        end else begin
          chk({tag, ".mem_wait_strobe"}, {mem_read, mem_write}, {e.lw, e.sw});
          chk({tag, ".mem_wait_err"},    mem_err, 0);
          chk({tag, ".mem_wait_done"},   done, 0);
        end
      end
      chk({tag, ".strobe_cycles"}, strobes, timed_out ? MEM_TIMEOUT : mem_wait);
      if (e.sw || timed_out) begin
        tick;
        idle_checks(tag);
        return;
      end
    end
    tick;
    mem_ready = 1'b0;
    #1;
    chk({tag, ".wb_wr"},     RegWrite, e.wr);
    chk({tag, ".wb_done"},   done, 1);
    chk({tag, ".wb_regdst"}, RegDst, e.rdst);
    chk({tag, ".wb_alu"},    alu_op, e.alu);
    chk({tag, ".wb_ready"},  instr_ready, 0);
    tick;
    idle_checks(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [4:0]  f_rs, f_rt, f_rd;
    int          mw;

    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    #2;
    chk("reset_outs", all_outs, 0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("post_reset_ready", instr_ready, 1);
    chk("post_reset_outs", all_outs & 28'h7FF_FFFF, 0);

    run_instr(32'h0022_1820, 0, "add");
    run_instr(32'h8C25_0004, 3, "lw3");
    run_instr(32'hAC25_0004, -1, "sw_timeout");
    run_instr(32'h2020_0007, 0, "addi_r0");
    run_instr(32'hFC00_0000, 0, "bad_op");
    run_instr(32'h0022_1821, 0, "bad_funct");
    run_instr(32'h1022_0003, 0, "beq");
    run_instr(32'h8C25_0004, MEM_TIMEOUT + 1, "lw_ready_on_timeout");
    run_instr(32'hAC25_0004, 1, "sw1");
    run_instr(32'h0022_182A, 0, "slt");

    // Reset in the middle of a load's MEM wait.
    instr = 32'h8C25_0004;
    instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("rstmid_mem_read", mem_read, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_outs", all_outs, 0);
    tick;
    chk("rstmid_outs_held", all_outs, 0);
    rst = 1'b0;
    #1;
    run_instr(32'h0022_1822, 0, "sub_after_rst");

    for (int n = 0; n < 60; n++) begin
      f_rs = 5'($urandom_range(0, 7));
      f_rt = 5'($urandom_range(0, 7));
      f_rd = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: w = {6'd0, f_rs, f_rt, f_rd, 5'($urandom),
                           6'(functs[$urandom_range(0, 4)])};
        5: w = {6'd8,  f_rs, f_rt, 16'($urandom)};
        6: w = {6'd35, f_rs, f_rt, 16'($urandom)};
        7: w = {6'd43, f_rs, f_rt, 16'($urandom)};
        8: w = {6'd4,  f_rs, f_rt, 16'($urandom)};
        default: w = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: mw = -1;
        1: mw = MEM_TIMEOUT + 1;
        default: mw = int'($urandom_range(1, 6));
      endcase
      run_instr(w, mw, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
